// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit sll/sra datapath between two requesters; result registered, 1 cycle.
// Backpressure: a full result slot that is not being drained deasserts both readies; 1 op/cycle when drained.

module sll_32 (
   input  logic [31:0] a_i,
   input  logic [4:0]  shamt_i,
   output logic [31:0] y_o
);
   assign y_o = a_i << shamt_i;
endmodule

module sra_32 (
   input  logic [31:0] a_i,
   input  logic [4:0]  shamt_i,
   output logic [31:0] y_o
);
   assign y_o = $unsigned($signed(a_i) >>> shamt_i);
endmodule

module shift_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_op,
   input  logic [31:0] req0_a,
   input  logic [4:0]  req0_shamt,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_op,
   input  logic [31:0] req1_a,
   input  logic [4:0]  req1_shamt,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_id
);
   logic        res_valid_q, res_valid_d;
   logic [31:0] res_data_q, res_data_d;
   logic        res_id_q, res_id_d;
   logic        prio_q, prio_d;

   logic        slot_free;
   logic        gnt_any;
   logic        gnt_id;
   logic        xfer;
   logic        sel_op;
   logic [31:0] sel_a;
   logic [4:0]  sel_shamt;
   logic [31:0] sll_res;
   logic [31:0] sra_res;

   assign slot_free = !res_valid_q || res_ready;
   assign gnt_any   = req0_valid || req1_valid;
   // prio only breaks ties; a lone requester always wins
   assign gnt_id    = (req0_valid && req1_valid) ? prio_q : req1_valid;

   assign req0_ready = !reset && slot_free && gnt_any && !gnt_id;
   assign req1_ready = !reset && slot_free && gnt_any && gnt_id;
   assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   assign sel_op    = gnt_id ? req1_op    : req0_op;
   assign sel_a     = gnt_id ? req1_a     : req0_a;
   assign sel_shamt = gnt_id ? req1_shamt : req0_shamt;

   sll_32 u_sll (.a_i(sel_a), .shamt_i(sel_shamt), .y_o(sll_res));
   sra_32 u_sra (.a_i(sel_a), .shamt_i(sel_shamt), .y_o(sra_res));

   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      prio_d      = prio_q;
      if (xfer) begin
         res_valid_d = 1'b1;
         res_data_d  = sel_op ? sra_res : sll_res;
         res_id_d    = gnt_id;
         prio_d      = ~gnt_id;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         res_valid_q <= 1'b0;
         res_data_q  <= 32'h0;
         res_id_q    <= 1'b0;
         prio_q      <= 1'b0;
      end else begin
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
         prio_q      <= prio_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vector table, hand-written corner sequences and a random soak
// against a cycle model of grant/slot behaviour with a result scoreboard queue.
module tb_shift_arbiter;
   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req0_op;
   logic [31:0] req0_a;
   logic [4:0]  req0_shamt;
   logic        req1_valid, req1_ready, req1_op;
   logic [31:0] req1_a;
   logic [4:0]  req1_shamt;
   logic        res_valid, res_ready, res_id;
   logic [31:0] res_data;

   shift_arbiter dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_shamt(req0_shamt),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_shamt(req1_shamt),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] data;
      logic        id;
   } exp_t;

   typedef struct packed {
      logic        id;
      logic        op;
      logic [31:0] a;
      logic [4:0]  shamt;
      logic [31:0] exp;
   } vec_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   logic m_vld = 1'b0;
   logic m_prio = 1'b0;
   logic g0, g1;

   function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] a, input logic [4:0] sh);
      logic [31:0] fill;
      if (!op) return a << sh;
      fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
      return (a >> sh) | fill;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive, check at negedge against the model, advance model, return #1 after posedge.
   task automatic step(input logic v0, input logic o0, input logic [31:0] a0, input logic [4:0] s0,
                       input logic v1, input logic o1, input logic [31:0] a1, input logic [4:0] s1,
                       input logic rr);
      logic free, e0, e1;
      exp_t e;
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_shamt = s0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_shamt = s1;
      res_ready  = rr;
      @(negedge clock);
      free = !m_vld || rr;
      e0 = free && v0 && (!v1 || !m_prio);
      e1 = free && v1 && (!v0 ||  m_prio);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("ready_overlap", req0_ready && req1_ready, 1'b0);
      chk("res_valid", res_valid, m_vld);
      if (m_vld) begin
         if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
         end else begin
            chk("res_data", res_data, sb_q[0].data);
            chk("res_id", res_id, sb_q[0].id);
            if (rr) void'(sb_q.pop_front());
         end
         if (rr) m_vld = 1'b0;
      end
      if (e0) begin
         e.data = ref_shift(o0, a0, s0); e.id = 1'b0;
         sb_q.push_back(e); m_vld = 1'b1; m_prio = 1'b1;
      end
      if (e1) begin
         e.data = ref_shift(o1, a1, s1); e.id = 1'b1;
         sb_q.push_back(e); m_vld = 1'b1; m_prio = 1'b0;
      end
      g0 = req0_ready; g1 = req1_ready;
      @(posedge clock); #1;
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, rr);
   endtask

   // Reset with both requesters presenting work: nothing may be accepted.
   task automatic do_reset();
      reset = 1'b1;
      req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h1234_5678; req0_shamt = 5'd3;
      req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'h8765_4321; req1_shamt = 5'd7;
      res_ready = 1'b0;
      @(negedge clock);
      chk("rst_req0_ready", req0_ready, 1'b0);
      chk("rst_req1_ready", req1_ready, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      sb_q.delete(); m_vld = 1'b0; m_prio = 1'b0;
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_data", res_data, 32'h0);
      chk("rst_res_id", res_id, 1'b0);
   endtask

   vec_t tv[9];
   int   n0, n1;
   logic r_v[2], r_op[2];
   logic [31:0] r_a[2];
   logic [4:0]  r_sh[2];

   initial begin
      reset = 1'b1;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_shamt = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_shamt = 0;
      res_ready = 0;
      repeat (2) @(posedge clock);
      #1;
      do_reset();

      tv[0] = '{id:1'b0, op:1'b0, a:32'h0000_0001, shamt:5'd31, exp:32'h8000_0000};
      tv[1] = '{id:1'b1, op:1'b1, a:32'h8000_0000, shamt:5'd4,  exp:32'hF800_0000};
      tv[2] = '{id:1'b1, op:1'b1, a:32'h8000_0000, shamt:5'd0,  exp:32'h8000_0000};
      tv[3] = '{id:1'b0, op:1'b0, a:32'hDEAD_BEEF, shamt:5'd0,  exp:32'hDEAD_BEEF};
      tv[4] = '{id:1'b0, op:1'b0, a:32'hFFFF_FFFF, shamt:5'd16, exp:32'hFFFF_0000};
      tv[5] = '{id:1'b1, op:1'b1, a:32'h7FFF_FFFF, shamt:5'd31, exp:32'h0000_0000};
      tv[6] = '{id:1'b1, op:1'b1, a:32'h8000_0000, shamt:5'd31, exp:32'hFFFF_FFFF};
      tv[7] = '{id:1'b0, op:1'b1, a:32'h1234_5678, shamt:5'd4,  exp:32'h0123_4567};
      tv[8] = '{id:1'b1, op:1'b0, a:32'h1234_5678, shamt:5'd4,  exp:32'h2345_6780};

      for (int i = 0; i < 9; i++) begin
         step(!tv[i].id, tv[i].op, tv[i].a, tv[i].shamt,
               tv[i].id, tv[i].op, tv[i].a, tv[i].shamt, 1'b1);
         chk("vec_data", res_data, tv[i].exp);
         chk("vec_id", res_id, tv[i].id);
      end
      idle(1'b1);

      // Contention: alternate 0,1,0,1 starting from reset priority.
      do_reset();
      n0 = 0; n1 = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 32'h1 << i, 5'd1, 1'b1, 1'b1, 32'h8000_0000 >> i, 5'd2, 1'b1);
         n0 += int'(g0); n1 += int'(g1);
         chk("cont_res_id", res_id, i[0]);
      end
      chk("cont_pulses0", n0, 2);
      chk("cont_pulses1", n1, 2);
      idle(1'b1);

      // Backpressure: hold result 3 cycles, then drain and issue in the same cycle.
      do_reset();
      step(1'b1, 1'b0, 32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1);
      n0 = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 32'hF000_0000, 5'd8, 1'b1, 1'b0, 32'h3, 5'd1, 1'b0);
         n0 += int'(g0) + int'(g1);
         chk("bp_hold_data", res_data, 32'h0000_0F00);
      end
      chk("bp_ready_pulses", n0, 0);
      step(1'b1, 1'b1, 32'hF000_0000, 5'd8, 1'b1, 1'b0, 32'h3, 5'd1, 1'b1);
      chk("bp_issue_same_cycle", g1, 1'b1);
      chk("bp_new_data", res_data, 32'h0000_0006);
      idle(1'b1);

      // Reset mid-stream with a pending result and prio=1.
      step(1'b1, 1'b0, 32'h5, 5'd1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1);
      chk("mid_pending", res_valid, 1'b1);
      do_reset();
      step(1'b1, 1'b0, 32'h7, 5'd2, 1'b1, 1'b1, 32'h8, 5'd1, 1'b1);
      chk("mid_first_grant0", g0, 1'b1);
      idle(1'b1);

      // Random soak; each requester holds its op until transferred.
      for (int n = 0; n < 2; n++) r_v[n] = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!r_v[n]) begin
               r_v[n]  = ($urandom_range(0, 2) != 0);
               r_op[n] = $urandom_range(0, 1) != 0;
               r_a[n]  = $urandom;
               r_sh[n] = 5'($urandom_range(0, 31));
            end
         end
         step(r_v[0], r_op[0], r_a[0], r_sh[0], r_v[1], r_op[1], r_a[1], r_sh[1],
              $urandom_range(0, 3) != 0);
         if (g0) r_v[0] = 1'b0;
         if (g1) r_v[1] = 1'b0;
      end
      idle(1'b1);
      idle(1'b1);
      chk("drain_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
